button_switch_conditioner: RTL and testbench



---
 rtl/button_switch_conditioner_if.sv | 38 +++
 rtl/button_switch_conditioner.sv | 108 ++++++++++
 tb/tb_button_switch_conditioner.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/button_switch_conditioner_if.sv
// Board-input bundle between the raw pins and the LED datapath: raw switches and
// buttons in, synchronized switches plus debounced button levels and press pulses out.
interface button_switch_conditioner_if #(
    parameter int SW_WIDTH = 16
);
    logic [SW_WIDTH-1:0] sw;
    logic                btnu;
    logic                btnd;
    logic                btnl;
    logic                btnr;

    logic [SW_WIDTH-1:0] sw_sync;
    logic                btnu_db;
    logic                btnd_db;
    logic                btnl_db;
    logic                btnr_db;
    logic                btnu_press;
    logic                btnd_press;
    logic                btnl_press;
    logic                btnr_press;
    logic                any_btn;

    modport master (
        output sw, btnu, btnd, btnl, btnr,
        input  sw_sync,
        input  btnu_db, btnd_db, btnl_db, btnr_db,
        input  btnu_press, btnd_press, btnl_press, btnr_press,
        input  any_btn
    );

    modport slave (
        input  sw, btnu, btnd, btnl, btnr,
        output sw_sync,
        output btnu_db, btnd_db, btnl_db, btnr_db,
        output btnu_press, btnd_press, btnl_press, btnr_press,
        output any_btn
    );
endinterface

// File: rtl/button_switch_conditioner.sv
// Brings the board's slide switches and push buttons into the clk domain; buttons are
// debounced independently and produce a clean level plus a one-cycle press pulse.
module button_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SW_WIDTH        = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    button_switch_conditioner_if.slave bus
);
    localparam int NBTN  = 4;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_e;

    logic [SW_WIDTH-1:0] sw_p1;
    logic [SW_WIDTH-1:0] sw_p2;

    // Button bit order: 0=up, 1=down, 2=left, 3=right.
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_p1;
    logic [NBTN-1:0] btn_p2;
    logic [NBTN-1:0] db;
    logic [NBTN-1:0] press;

    assign btn_raw = {bus.btnr, bus.btnl, bus.btnd, bus.btnu};

    // Stage p1/p2: two-flop synchronizers for switches and buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_p1  <= '0;
            sw_p2  <= '0;
            btn_p1 <= '0;
            btn_p2 <= '0;
        end else begin
            sw_p1  <= bus.sw;
            sw_p2  <= sw_p1;
            btn_p1 <= btn_raw;
            btn_p2 <= btn_p1;
        end
    end

    // Stage p3: per-button debounce; state is implied by whether s2 disagrees with db
    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        db_state_e        state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             db_r;
        logic             db_nxt;
        logic             press_r;
        logic             press_nxt;

        always_comb begin
            state     = (btn_p2[i] == db_r) ? STABLE : COUNTING;
            cnt_nxt   = '0;
            db_nxt    = db_r;
            press_nxt = 1'b0;
            unique case (state)
                STABLE: begin
                    cnt_nxt = '0;
                end
                COUNTING: begin
                    if (cnt == CNT_MAX) begin
                        db_nxt    = btn_p2[i];
                        press_nxt = btn_p2[i];
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_nxt = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt     <= '0;
                db_r    <= 1'b0;
                press_r <= 1'b0;
            end else begin
                cnt     <= cnt_nxt;
                db_r    <= db_nxt;
                press_r <= press_nxt;
            end
        end

        assign db[i]    = db_r;
        assign press[i] = press_r;
    end

    assign bus.sw_sync    = sw_p2;
    assign bus.btnu_db    = db[0];
    assign bus.btnd_db    = db[1];
    assign bus.btnl_db    = db[2];
    assign bus.btnr_db    = db[3];
    assign bus.btnu_press = press[0];
    assign bus.btnd_press = press[1];
    assign bus.btnl_press = press[2];
    assign bus.btnr_press = press[3];
    // OR of registered levels only, so no combinational glitches reach any_btn.
    assign bus.any_btn    = |db;
endmodule

// File: tb/tb_button_switch_conditioner.sv
// Directed bench for button_switch_conditioner with DEBOUNCE_CYCLES=4: stimulus queues
// per-edge expectations, an independent negedge monitor pops and compares them.
module tb_button_switch_conditioner;
    localparam int SW_WIDTH = 16;
    localparam int DB       = 4;

    // Observed control bits: [3:0]=db {r,l,d,u}, [7:4]=press {r,l,d,u}, [8]=any_btn
    localparam int U = 0;
    localparam int D = 1;
    localparam int L = 2;
    localparam int R = 3;
    localparam logic [8:0] ALL = 9'h1FF;
    localparam logic [8:0] ANY = 9'h100;

    typedef struct {
        int                  at;
        logic [8:0]          mask;
        logic [8:0]          val;
        bit                  chk_sw;
        logic [SW_WIDTH-1:0] swv;
        string               name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    exp_t q[$];

    button_switch_conditioner_if #(.SW_WIDTH(SW_WIDTH)) ifc ();

    button_switch_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .SW_WIDTH       (SW_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] dbm(int b);
        return 9'(1 << b);
    endfunction

    function automatic logic [8:0] prm(int b);
        return 9'(1 << (4 + b));
    endfunction

    function automatic void expect_ctl(int at, logic [8:0] mask, logic [8:0] val, string name);
        exp_t e;
        e.at = at; e.mask = mask; e.val = val; e.chk_sw = 1'b0; e.swv = '0; e.name = name;
        q.push_back(e);
    endfunction

    function automatic void expect_sw(int at, logic [SW_WIDTH-1:0] swv, string name);
        exp_t e;
        e.at = at; e.mask = '0; e.val = '0; e.chk_sw = 1'b1; e.swv = swv; e.name = name;
        q.push_back(e);
    endfunction

    // Monitor: compares every expectation scheduled for the edge just completed
    always @(negedge clk) begin
        logic [8:0] obs;
        obs = {ifc.any_btn, ifc.btnr_press, ifc.btnl_press, ifc.btnd_press, ifc.btnu_press,
               ifc.btnr_db, ifc.btnl_db, ifc.btnd_db, ifc.btnu_db};
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.at < cyc) begin
                failures++;
                $display("FAIL %s: expectation for edge %0d missed at edge %0d", e.name, e.at, cyc);
            end else if (e.chk_sw) begin
                if (ifc.sw_sync !== e.swv) begin
                    failures++;
                    $display("FAIL %s: edge %0d sw_sync=%h expected %h", e.name, cyc, ifc.sw_sync, e.swv);
                end
            end else if ((obs & e.mask) !== e.val) begin
                failures++;
                $display("FAIL %s: edge %0d ctl=%b expected %b (mask %b)", e.name, cyc, obs & e.mask, e.val, e.mask);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int e0;
        checks   = 0;
        failures = 0;

        // Reset with every input high: all outputs must read 0
        reset    = 1'b1;
        ifc.sw   = 16'hFFFF;
        ifc.btnu = 1'b1;
        ifc.btnd = 1'b1;
        ifc.btnl = 1'b1;
        ifc.btnr = 1'b1;
        expect_ctl(1, ALL, 9'h000, "reset_ctl_e1");
        expect_sw (2, 16'h0000,    "reset_sw_e2");
        expect_ctl(3, ALL, 9'h000, "reset_ctl_e3");
        tick(3);

        // Release with btnu held: level rises 6 edges later with a single pulse
        reset    = 1'b0;
        ifc.sw   = 16'h0000;
        ifc.btnd = 1'b0;
        ifc.btnl = 1'b0;
        ifc.btnr = 1'b0;
        e0 = cyc;
        expect_ctl(e0 + 5, ALL, 9'h000,                 "rst_u_before");
        expect_ctl(e0 + 6, ALL, ANY | dbm(U) | prm(U),  "rst_u_rise");
        expect_ctl(e0 + 7, ALL, ANY | dbm(U),           "rst_u_pulse_end");
        tick(10);
        ifc.btnu = 1'b0;
        tick(10);

        // Switch synchronizer: two-edge delay, no debounce
        ifc.sw = 16'hA5F0;
        e0 = cyc;
        expect_sw(e0 + 1, 16'h0000, "sw_a5f0_early");
        expect_sw(e0 + 2, 16'hA5F0, "sw_a5f0");
        tick(3);
        ifc.sw = 16'h5A0F;
        e0 = cyc;
        expect_sw(e0 + 1, 16'hA5F0, "sw_5a0f_early");
        expect_sw(e0 + 2, 16'h5A0F, "sw_5a0f");
        tick(3);

        // Bounce rejection on btnl: 2-cycle bounces never reach the threshold
        e0 = cyc;
        expect_ctl(e0 + 6,  dbm(L) | prm(L), 9'h000,                "bounce_l_mid");
        expect_ctl(e0 + 10, dbm(L) | prm(L), 9'h000,                "bounce_l_late");
        expect_ctl(e0 + 13, dbm(L) | prm(L), 9'h000,                "bounce_l_before");
        expect_ctl(e0 + 14, ALL,             ANY | dbm(L) | prm(L), "bounce_l_rise");
        expect_ctl(e0 + 15, ALL,             ANY | dbm(L),          "bounce_l_pulse_end");
        ifc.btnl = 1'b1; tick(2);
        ifc.btnl = 1'b0; tick(2);
        ifc.btnl = 1'b1; tick(2);
        ifc.btnl = 1'b0; tick(2);
        ifc.btnl = 1'b1; tick(10);
        ifc.btnl = 1'b0; tick(10);

        // Release of btnr: level falls 6 edges later, no pulse, any_btn follows
        ifc.btnr = 1'b1;
        e0 = cyc;
        expect_ctl(e0 + 6, ALL, ANY | dbm(R) | prm(R), "hold_r_rise");
        tick(8);
        ifc.btnr = 1'b0;
        e0 = cyc;
        expect_ctl(e0 + 5, ALL, ANY | dbm(R), "release_r_before");
        expect_ctl(e0 + 6, ALL, 9'h000,       "release_r_fall");
        expect_ctl(e0 + 7, ALL, 9'h000,       "release_r_after");
        tick(10);

        // Simultaneous presses on up and down
        ifc.btnu = 1'b1;
        ifc.btnd = 1'b1;
        e0 = cyc;
        expect_ctl(e0 + 5, ALL, 9'h000,                                      "simul_before");
        expect_ctl(e0 + 6, ALL, ANY | dbm(U) | dbm(D) | prm(U) | prm(D),     "simul_rise");
        expect_ctl(e0 + 7, ALL, ANY | dbm(U) | dbm(D),                       "simul_pulse_end");
        tick(10);
        ifc.btnu = 1'b0;
        ifc.btnd = 1'b0;
        tick(10);

        // Reset in the middle of a count: fresh 6-edge count after release
        ifc.btnd = 1'b1;
        e0 = cyc;
        expect_ctl(e0 + 3, ALL, 9'h000, "midrst_counting");
        expect_ctl(e0 + 4, ALL, 9'h000, "midrst_in_reset");
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        e0 = cyc;
        expect_ctl(e0 + 5, ALL, 9'h000,                "midrst_before");
        expect_ctl(e0 + 6, ALL, ANY | dbm(D) | prm(D), "midrst_rise");
        expect_ctl(e0 + 7, ALL, ANY | dbm(D),          "midrst_pulse_end");
        tick(10);
        ifc.btnd = 1'b0;

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
